// File: rtl/midi_tx_wb_if.sv
// Wishbone-style 8-bit register bus between the SPI bridge (master) and midi_tx_wb (slave).
// Member names keep the slave-side port names of the original block.
interface midi_tx_wb_if;
  logic [7:0] wb_addr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_ack_o;

  modport master (
    output wb_addr_i, wb_dat_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_addr_i, wb_dat_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/midi_tx_wb.sv
// Wishbone slave with TX FIFO and 31250-baud MIDI serializer (8N1, LSB first).
// Define MIDI_TX_IRQ_EN to add CTRL.IRQEN and the half-empty irq_o output.
module midi_tx_wb #(
  parameter int unsigned CLK_DIV = 32,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n_i,
  midi_tx_wb_if.slave    wb,
`ifdef MIDI_TX_IRQ_EN
  output logic           irq_o,
`endif
  output logic           midi_tx_o
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned TW    = $clog2(CLK_DIV);
  localparam logic [FIFO_AW:0] FULL_LVL = DEPTH[FIFO_AW:0];
  localparam logic [TW-1:0]    TC_VAL   = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               txen_q, txen_d;
  logic               ack_q, ack_d;
  logic [7:0]         dat_q, dat_d;
  logic [7:0]         mem_q [DEPTH];
  logic               irqen_rd;

  logic access, wr_data, wr_status, wr_ctrl, flush;
  logic full, empty, push_ok, can_pop, pop, tc;

  assign access    = wb.wb_stb_i & ~ack_q;
  assign wr_data   = access & wb.wb_we_i & (wb.wb_addr_i == 8'h00);
  assign wr_status = access & wb.wb_we_i & (wb.wb_addr_i == 8'h01);
  assign wr_ctrl   = access & wb.wb_we_i & (wb.wb_addr_i == 8'h03);
  assign flush     = wr_ctrl & wb.wb_dat_i[1];
  assign full      = (count_q == FULL_LVL);
  assign empty     = (count_q == '0);
  assign push_ok   = wr_data & ~full;
  // A flush wins over a same-cycle pop so no flushed byte can reach the line.
  assign can_pop   = txen_q & ~empty & ~flush;
  assign tc        = (timer_q == TC_VAL);

`ifdef MIDI_TX_IRQ_EN
  localparam logic [FIFO_AW:0] HALF_LVL = FULL_LVL >> 1;
  logic irqen_q, irqen_d, irq_q, irq_d;

  always_comb begin
    irqen_d = irqen_q;
    if (wr_ctrl) irqen_d = wb.wb_dat_i[2];
    irq_d = irqen_q & (count_q <= HALF_LVL);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end

  assign irqen_rd = irqen_q;
  assign irq_o    = irq_q;
`else
  assign irqen_rd = 1'b0;
`endif

  // Serializer: line level is registered from the current state, adding one cycle of latency.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) timer_d = tc ? '0 : timer_q + 1'b1;
    unique case (state_q)
      S_IDLE: if (can_pop) begin
        pop     = 1'b1;
        shift_d = mem_q[rd_ptr_q];
        timer_d = '0;
        state_d = S_START;
      end
      S_START: if (tc) begin
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (tc) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (tc) begin
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    unique case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping and register file.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    txen_d   = txen_q;
    ack_d    = access;
    dat_d    = '0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (!push_ok && pop) count_d = count_q - 1'b1;
    end
    if (wr_data && full) ovf_d = 1'b1;
    if (wr_status && wb.wb_dat_i[3]) ovf_d = 1'b0;
    if (wr_ctrl) txen_d = wb.wb_dat_i[0];
    if (access && !wb.wb_we_i) begin
      unique case (wb.wb_addr_i)
        8'h01:   dat_d = {4'b0, ovf_q, state_q != S_IDLE, full, empty};
        8'h02:   dat_d = 8'(count_q);
        8'h03:   dat_d = {5'b0, irqen_rd, 1'b0, txen_q};
        default: dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wb.wb_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      txen_q   <= 1'b1;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      txen_q   <= txen_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign midi_tx_o   = tx_q;

endmodule

// File: tb/tb_midi_tx_wb.sv
// Directed bench for midi_tx_wb with CLK_DIV=4: register map, frame timing, FIFO full/flush, async reset.
module tb_midi_tx_wb;
  localparam int unsigned CD = 4;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
`ifdef MIDI_TX_IRQ_EN
  logic irq;
`endif
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  midi_tx_wb_if bus ();

  midi_tx_wb #(.CLK_DIV(CD), .FIFO_AW(AW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus.slave),
`ifdef MIDI_TX_IRQ_EN
    .irq_o      (irq),
`endif
    .midi_tx_o  (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected line level k cycles after the start bit first appears.
  function automatic logic line_bit(input logic [7:0] b, input int unsigned k);
    int unsigned s;
    s = k / CD;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    return 1'b1;
  endfunction

  task automatic wb_xfer(input logic we, input logic [7:0] a, input logic [7:0] d, output logic [7:0] r);
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = we; bus.wb_addr_i = a; bus.wb_dat_i = d;
    @(posedge clk); #1;
    r = bus.wb_dat_o;
    @(negedge clk);
    bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    wb_xfer(1'b1, a, d, r);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] r;
    wb_xfer(1'b0, a, 8'h00, r);
    check(tag, r, exp);
  endtask

  task automatic wait_fall(input string tag, output int unsigned t0);
    t0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx == 1'b0) break;
    end
    t0 = cyc;
    check(tag, tx, 1'b0);
  endtask

  initial begin
    int unsigned t0, errs, k;
    logic [63:0] got_v, exp_v;
    bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_addr_i = '0; bus.wb_dat_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", bus.wb_ack_o, 1'b0);
    check("rst_dat", bus.wb_dat_o, 8'h00);
    check("rst_tx", tx, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    rd_chk("status_rst", 8'h01, 8'h01);
    rd_chk("level_rst", 8'h02, 8'h00);
    rd_chk("ctrl_rst", 8'h03, 8'h01);
    rd_chk("txdata_rd", 8'h00, 8'h00);
    rd_chk("unmapped_rd", 8'h7F, 8'h00);
    check("tx_idle", tx, 1'b1);

    // Single frame 0x90 with exact latency from the ack edge.
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_addr_i = 8'h00; bus.wb_dat_i = 8'h90;
    @(posedge clk); #1;
    check("ack_wr", bus.wb_ack_o, 1'b1);
    check("tx_ack_edge", tx, 1'b1);
    @(negedge clk);
    bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", bus.wb_ack_o, 1'b0);
    check("tx_ack_p1", tx, 1'b1);
    got_v = '0; exp_v = '0;
    for (int unsigned i = 0; i < 44; i++) begin
      @(posedge clk); #1;
      got_v[i] = tx;
      exp_v[i] = line_bit(8'h90, i);
    end
    check("frame_90", got_v, exp_v);
    rd_chk("status_after90", 8'h01, 8'h01);

    // Fill with TXEN=0, overflow on the 17th byte, clear OVF, then drain contiguously.
    wr(8'h03, 8'h00);
    for (int unsigned i = 0; i < 17; i++) wr(8'h00, 8'(8'h30 + i));
    rd_chk("level_full", 8'h02, 8'h10);
    rd_chk("status_full_ovf", 8'h01, 8'h0A);
    wr(8'h01, 8'h08);
    rd_chk("status_ovf_clr", 8'h01, 8'h02);
    wr(8'h03, 8'h01);
    wait_fall("stream_fall", t0);
    errs = 0;
    for (int unsigned i = 0; i < 16 * 10 * CD + 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i < 160 * CD) begin
        if (tx !== line_bit(8'(8'h30 + i / (10 * CD)), i % (10 * CD))) errs++;
      end else if (tx !== 1'b1) errs++;
    end
    check("stream_errs", errs, 0);
    rd_chk("status_drained", 8'h01, 8'h01);

    // Flush mid-frame: current frame finishes, queued bytes vanish.
    wr(8'h03, 8'h00);
    wr(8'h00, 8'hA5); wr(8'h00, 8'h11); wr(8'h00, 8'h22); wr(8'h00, 8'h33);
    wr(8'h03, 8'h01);
    wait_fall("flush_fall", t0);
    rd_chk("level_before_flush", 8'h02, 8'h03);
    wr(8'h03, 8'h03);
    rd_chk("level_after_flush", 8'h02, 8'h00);
    errs = 0;
    while (cyc - t0 < 60) begin
      @(posedge clk); #1;
      k = cyc - t0;
      if (tx !== line_bit(8'hA5, k)) errs++;
    end
    check("flush_frame_errs", errs, 0);
    rd_chk("status_after_flush", 8'h01, 8'h01);
    rd_chk("ctrl_flush_rd0", 8'h03, 8'h01);

    // Strobe held high for 6 edges yields 3 accesses.
    wr(8'h03, 8'h00);
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_addr_i = 8'h00; bus.wb_dat_i = 8'h55;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    rd_chk("level_held_stb", 8'h02, 8'h03);
    wr(8'h03, 8'h02);
    rd_chk("level_flush_txen0", 8'h02, 8'h00);
    rd_chk("ctrl_txen0", 8'h03, 8'h00);
    wr(8'h03, 8'h01);

    // Asynchronous reset during DATA while an ack is high.
    wr(8'h00, 8'h00);
    wait_fall("rst_fall", t0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_addr_i = 8'h02;
    @(posedge clk); #1;
    check("pre_rst_ack", bus.wb_ack_o, 1'b1);
    check("pre_rst_tx", tx, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_ack", bus.wb_ack_o, 1'b0);
    check("async_rst_dat", bus.wb_dat_o, 8'h00);
    @(negedge clk);
    bus.wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("status_post_rst", 8'h01, 8'h01);
    rd_chk("level_post_rst", 8'h02, 8'h00);
    check("tx_post_rst", tx, 1'b1);

`ifdef MIDI_TX_IRQ_EN
    wr(8'h03, 8'h04);
    @(posedge clk); #1;
    check("irq_empty", irq, 1'b1);
    for (int unsigned i = 0; i < 9; i++) wr(8'h00, 8'(8'h60 + i));
    @(posedge clk); #1;
    check("irq_lvl9", irq, 1'b0);
    rd_chk("ctrl_irqen", 8'h03, 8'h04);
    wr(8'h03, 8'h05);
    @(posedge clk); #1;
    check("irq_lvl8_lag", irq, 1'b0);
    @(posedge clk); #1;
    check("irq_lvl8", irq, 1'b1);
`else
    wr(8'h03, 8'h05);
    rd_chk("ctrl_no_irqen", 8'h03, 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
